// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: memory op codes, load-select
// bit indices, address-error exception codes, FSM states and the entry record.
package mem_access_stage_pkg;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_LWL  = 4'd6,
    MEM_OP_LWR  = 4'd7,
    MEM_OP_SB   = 4'd8,
    MEM_OP_SH   = 4'd9,
    MEM_OP_SW   = 4'd10,
    MEM_OP_SWL  = 4'd11,
    MEM_OP_SWR  = 4'd12
  } mem_op_e;

  localparam int LOAD_SEL_W   = 11;
  localparam int LOAD_LB_BIT  = 0;
  localparam int LOAD_LBU_BIT = 1;
  localparam int LOAD_LH_BIT  = 2;
  localparam int LOAD_LHU_BIT = 3;
  localparam int LOAD_LW_BIT  = 4;
  localparam int LOAD_L0_BIT  = 5;
  localparam int LOAD_L1_BIT  = 6;
  localparam int LOAD_L2_BIT  = 7;
  localparam int LOAD_R1_BIT  = 8;
  localparam int LOAD_R2_BIT  = 9;
  localparam int LOAD_R3_BIT  = 10;

  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_WAIT_BUS = 2'd1,
    ST_READY    = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [4:0]            write_num;
    logic                  exc;
    logic [4:0]            exc_code;
    logic [31:0]           bad_vaddr;
    logic                  mem_req;
    logic [LOAD_SEL_W-1:0] load_sel;
    logic [1:0]            align;
    logic [31:0]           final_res;
    logic [31:0]           rt_data;
    logic [31:0]           pc;
    logic                  dangerous;
    logic                  wr;
    logic [3:0]            wstrb;
    logic [31:0]           wdata;
  } mem_entry_t;

endpackage

// File: rtl/mem_lsu_encode.sv
// Combinational load/store decode: byte strobes, store data, one-hot load
// selector and address-error flags. Unaligned LWL/LWR/SWL/SWR need MEM_UNALIGNED_LS_EN.
module mem_lsu_encode
  import mem_access_stage_pkg::*;
(
  input  logic [3:0]            mem_op,
  input  logic [1:0]            addr_lo,
  input  logic [31:0]           rt,
  output logic                  is_load,
  output logic                  is_store,
  output logic                  ade_l,
  output logic                  ade_s,
  output logic [3:0]            wstrb,
  output logic [31:0]           wdata,
  output logic [LOAD_SEL_W-1:0] load_sel
);

  mem_op_e op;

  always_comb begin
    op       = mem_op_e'(mem_op);
`ifndef MEM_UNALIGNED_LS_EN
    // Without unaligned support the partial-word ops fold onto the word ops.
    if (op == MEM_OP_LWL || op == MEM_OP_LWR) op = MEM_OP_LW;
    if (op == MEM_OP_SWL || op == MEM_OP_SWR) op = MEM_OP_SW;
`endif
    is_load  = 1'b0;
    is_store = 1'b0;
    ade_l    = 1'b0;
    ade_s    = 1'b0;
    wstrb    = '0;
    wdata    = '0;
    load_sel = '0;
    case (op)
      MEM_OP_LB: begin
        is_load = 1'b1;
        load_sel[LOAD_LB_BIT] = 1'b1;
      end
      MEM_OP_LBU: begin
        is_load = 1'b1;
        load_sel[LOAD_LBU_BIT] = 1'b1;
      end
      MEM_OP_LH: begin
        is_load = 1'b1;
        ade_l   = addr_lo[0];
        load_sel[LOAD_LH_BIT] = 1'b1;
      end
      MEM_OP_LHU: begin
        is_load = 1'b1;
        ade_l   = addr_lo[0];
        load_sel[LOAD_LHU_BIT] = 1'b1;
      end
      MEM_OP_LW: begin
        is_load = 1'b1;
        ade_l   = (addr_lo != 2'd0);
        load_sel[LOAD_LW_BIT] = 1'b1;
      end
`ifdef MEM_UNALIGNED_LS_EN
      MEM_OP_LWL: begin
        is_load = 1'b1;
        case (addr_lo)
          2'd0:    load_sel[LOAD_L0_BIT] = 1'b1;
          2'd1:    load_sel[LOAD_L1_BIT] = 1'b1;
          2'd2:    load_sel[LOAD_L2_BIT] = 1'b1;
          default: load_sel[LOAD_LW_BIT] = 1'b1;
        endcase
      end
      MEM_OP_LWR: begin
        is_load = 1'b1;
        case (addr_lo)
          2'd3:    load_sel[LOAD_R3_BIT] = 1'b1;
          2'd2:    load_sel[LOAD_R2_BIT] = 1'b1;
          2'd1:    load_sel[LOAD_R1_BIT] = 1'b1;
          default: load_sel[LOAD_LW_BIT] = 1'b1;
        endcase
      end
`endif
      MEM_OP_SB: begin
        is_store = 1'b1;
        wstrb    = 4'b0001 << addr_lo;
        wdata    = {4{rt[7:0]}};
      end
      MEM_OP_SH: begin
        is_store = 1'b1;
        ade_s    = addr_lo[0];
        wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{rt[15:0]}};
      end
      MEM_OP_SW: begin
        is_store = 1'b1;
        ade_s    = (addr_lo != 2'd0);
        wstrb    = 4'b1111;
        wdata    = rt;
      end
`ifdef MEM_UNALIGNED_LS_EN
      MEM_OP_SWL: begin
        is_store = 1'b1;
        case (addr_lo)
          2'd0:    wstrb = 4'b0001;
          2'd1:    wstrb = 4'b0011;
          2'd2:    wstrb = 4'b0111;
          default: wstrb = 4'b1111;
        endcase
        wdata = rt >> (5'd24 - {addr_lo, 3'b000});
      end
      MEM_OP_SWR: begin
        is_store = 1'b1;
        wstrb    = 4'b1111 << addr_lo;
        wdata    = rt << {addr_lo, 3'b000};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: latches the EXE result, issues the data-bus request and
// runs the valid/allowin interlock. Unaligned ops gated by MEM_UNALIGNED_LS_EN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EXE_valid_w_i,
  input  logic                  WB_allowin_w_i,
  input  logic                  flush_w_i,
  input  logic [4:0]            EXE_writeNum_i,
  input  logic [DATA_W-1:0]     EXE_finalRes_i,
  input  logic [DATA_W-1:0]     EXE_rtData_i,
  input  logic [3:0]            EXE_memOp_i,
  input  logic [ADDR_W-1:0]     EXE_pc_i,
  input  logic                  EXE_isDangerous_i,
  output logic                  MEM_allowin_w_o,
  output logic                  MEM_valid_w_o,
  output logic [4:0]            MEM_writeNum_w_o,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [3:0]            data_wstrb,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  output logic [4:0]            MEM_writeNum_o,
  output logic                  MEM_exceptionRisk_o,
  output logic [4:0]            MEM_excCode_o,
  output logic [ADDR_W-1:0]     MEM_badVAddr_o,
  output logic                  MEM_memReq_o,
  output logic [ADDR_W-1:0]     MEM_VAddr_o,
  output logic                  MEM_isDangerous_o,
  output logic [DATA_W-1:0]     MEM_finalRes_o,
  output logic [DATA_W-1:0]     MEM_rtData_o,
  output logic [1:0]            MEM_alignCheck_o,
  output logic [LOAD_SEL_W-1:0] MEM_loadSel_o
);

  mem_state_e state_q;
  mem_entry_t entry_q;
  mem_entry_t entry_d;

  logic                  is_load, is_store, ade_l, ade_s, ade, bus_op;
  logic [3:0]            enc_wstrb;
  logic [31:0]           enc_wdata;
  logic [LOAD_SEL_W-1:0] enc_load_sel;

  // Decode on the EXE side so the FSM knows the entry's class as it loads.
  mem_lsu_encode u_encode (
    .mem_op   (EXE_memOp_i),
    .addr_lo  (EXE_finalRes_i[1:0]),
    .rt       (EXE_rtData_i),
    .is_load  (is_load),
    .is_store (is_store),
    .ade_l    (ade_l),
    .ade_s    (ade_s),
    .wstrb    (enc_wstrb),
    .wdata    (enc_wdata),
    .load_sel (enc_load_sel)
  );

  assign ade    = ade_l | ade_s;
  assign bus_op = (is_load | is_store) & ~ade;

  always_comb begin
    entry_d           = '0;
    entry_d.write_num = ade ? 5'd0 : EXE_writeNum_i;
    entry_d.exc       = ade;
    entry_d.exc_code  = ade_l ? EXC_ADEL : (ade_s ? EXC_ADES : 5'd0);
    entry_d.bad_vaddr = ade ? EXE_finalRes_i : '0;
    entry_d.mem_req   = is_load & ~ade;
    entry_d.load_sel  = enc_load_sel;
    entry_d.align     = EXE_finalRes_i[1:0];
    entry_d.final_res = EXE_finalRes_i;
    entry_d.rt_data   = EXE_rtData_i;
    entry_d.pc        = EXE_pc_i;
    entry_d.dangerous = EXE_isDangerous_i;
    entry_d.wr        = is_store & ~ade;
    entry_d.wstrb     = ade ? 4'b0000 : enc_wstrb;
    entry_d.wdata     = ade ? '0 : enc_wdata;
  end

  assign data_req        = (state_q == ST_WAIT_BUS) && WB_allowin_w_i && !flush_w_i;
  assign MEM_valid_w_o   = (state_q == ST_READY) ||
                           ((state_q == ST_WAIT_BUS) && data_req && data_addr_ok);
  assign MEM_allowin_w_o = (state_q == ST_EMPTY) || (MEM_valid_w_o && WB_allowin_w_i);
  assign MEM_writeNum_w_o = (state_q == ST_EMPTY) ? 5'd0 : entry_q.write_num;

  // An accepted WAIT_BUS entry leaves through allowin in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      entry_q <= '0;
    end else if (flush_w_i || (MEM_allowin_w_o && !EXE_valid_w_i)) begin
      state_q <= ST_EMPTY;
      entry_q <= '0;
    end else if (MEM_allowin_w_o) begin
      state_q <= bus_op ? ST_WAIT_BUS : ST_READY;
      entry_q <= entry_d;
    end
  end

  assign data_wr             = entry_q.wr;
  assign data_wstrb          = entry_q.wstrb;
  assign data_addr           = entry_q.final_res;
  assign data_wdata          = entry_q.wdata;
  assign MEM_writeNum_o      = entry_q.write_num;
  assign MEM_exceptionRisk_o = entry_q.exc;
  assign MEM_excCode_o       = entry_q.exc_code;
  assign MEM_badVAddr_o      = entry_q.bad_vaddr;
  assign MEM_memReq_o        = entry_q.mem_req;
  assign MEM_VAddr_o         = entry_q.pc;
  assign MEM_isDangerous_o   = entry_q.dangerous;
  assign MEM_finalRes_o      = entry_q.final_res;
  assign MEM_rtData_o        = entry_q.rt_data;
  assign MEM_alignCheck_o    = entry_q.align;
  assign MEM_loadSel_o       = entry_q.load_sel;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage; expectations follow MEM_UNALIGNED_LS_EN.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk, rst;
  logic        EXE_valid_w_i, WB_allowin_w_i, flush_w_i;
  logic [4:0]  EXE_writeNum_i;
  logic [31:0] EXE_finalRes_i, EXE_rtData_i, EXE_pc_i;
  logic [3:0]  EXE_memOp_i;
  logic        EXE_isDangerous_i;
  logic        MEM_allowin_w_o, MEM_valid_w_o;
  logic [4:0]  MEM_writeNum_w_o;
  logic        data_req, data_wr, data_addr_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic [4:0]  MEM_writeNum_o;
  logic        MEM_exceptionRisk_o;
  logic [4:0]  MEM_excCode_o;
  logic [31:0] MEM_badVAddr_o;
  logic        MEM_memReq_o;
  logic [31:0] MEM_VAddr_o;
  logic        MEM_isDangerous_o;
  logic [31:0] MEM_finalRes_o, MEM_rtData_o;
  logic [1:0]  MEM_alignCheck_o;
  logic [10:0] MEM_loadSel_o;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .EXE_valid_w_i(EXE_valid_w_i), .WB_allowin_w_i(WB_allowin_w_i), .flush_w_i(flush_w_i),
    .EXE_writeNum_i(EXE_writeNum_i), .EXE_finalRes_i(EXE_finalRes_i),
    .EXE_rtData_i(EXE_rtData_i), .EXE_memOp_i(EXE_memOp_i), .EXE_pc_i(EXE_pc_i),
    .EXE_isDangerous_i(EXE_isDangerous_i),
    .MEM_allowin_w_o(MEM_allowin_w_o), .MEM_valid_w_o(MEM_valid_w_o),
    .MEM_writeNum_w_o(MEM_writeNum_w_o),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .MEM_writeNum_o(MEM_writeNum_o), .MEM_exceptionRisk_o(MEM_exceptionRisk_o),
    .MEM_excCode_o(MEM_excCode_o), .MEM_badVAddr_o(MEM_badVAddr_o),
    .MEM_memReq_o(MEM_memReq_o), .MEM_VAddr_o(MEM_VAddr_o),
    .MEM_isDangerous_o(MEM_isDangerous_o), .MEM_finalRes_o(MEM_finalRes_o),
    .MEM_rtData_o(MEM_rtData_o), .MEM_alignCheck_o(MEM_alignCheck_o),
    .MEM_loadSel_o(MEM_loadSel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wn;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] bad;
    logic        mreq;
    logic [10:0] lsel;
    logic [1:0]  al;
    logic [31:0] res;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   handovers = 0;

  logic [229:0] all_out;
  assign all_out = {data_req, data_wr, data_wstrb, data_addr, data_wdata, MEM_writeNum_o,
                    MEM_exceptionRisk_o, MEM_excCode_o, MEM_badVAddr_o, MEM_memReq_o,
                    MEM_VAddr_o, MEM_isDangerous_o, MEM_finalRes_o, MEM_rtData_o,
                    MEM_alignCheck_o, MEM_loadSel_o, MEM_writeNum_w_o, MEM_valid_w_o};

  function automatic exp_t mk(input logic [4:0] wn, input logic exc, input logic [4:0] code,
                              input logic [31:0] bad, input logic mreq, input int lbit,
                              input logic [31:0] res, input logic [31:0] pc);
    exp_t e;
    e.wn = wn; e.exc = exc; e.code = code; e.bad = bad; e.mreq = mreq;
    e.lsel = (lbit < 0) ? 11'd0 : (11'd1 << lbit);
    e.al = res[1:0]; e.res = res; e.pc = pc;
    return e;
  endfunction

  // WB side: every handover pops one expected entry
  always @(negedge clk) begin
    exp_t act, e;
    if (rst && MEM_valid_w_o && WB_allowin_w_i) begin
      handovers++;
      act = '{wn: MEM_writeNum_o, exc: MEM_exceptionRisk_o, code: MEM_excCode_o,
              bad: MEM_badVAddr_o, mreq: MEM_memReq_o, lsel: MEM_loadSel_o,
              al: MEM_alignCheck_o, res: MEM_finalRes_o, pc: MEM_VAddr_o};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL handover_unexpected: got %h, wanted no handover", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL handover: got %h, wanted %h", act, e);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [4:0] wn, input logic [31:0] pc);
    EXE_memOp_i = op; EXE_finalRes_i = addr; EXE_rtData_i = rt;
    EXE_writeNum_i = wn; EXE_pc_i = pc; EXE_valid_w_i = 1'b1;
    @(posedge clk); #1;
    EXE_valid_w_i = 1'b0; EXE_memOp_i = 4'd0;
  endtask

  task automatic test_reset;
    rst = 1'b0; EXE_valid_w_i = 0; WB_allowin_w_i = 0; flush_w_i = 0; data_addr_ok = 0;
    EXE_writeNum_i = 0; EXE_finalRes_i = 0; EXE_rtData_i = 0; EXE_memOp_i = 0;
    EXE_pc_i = 0; EXE_isDangerous_i = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, wanted 0", all_out); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({MEM_allowin_w_o, MEM_valid_w_o, data_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b, wanted 100", {MEM_allowin_w_o, MEM_valid_w_o, data_req});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_sb;
    WB_allowin_w_i = 1; data_addr_ok = 1;
    sb.push_back(mk(5'd0, 1'b0, 5'd0, 32'd0, 1'b0, LOAD_LB_BIT - 1, 32'h1002, 32'hBFC0_0010));
    issue(MEM_OP_SB, 32'h1002, 32'h1122_3344, 5'd0, 32'hBFC0_0010);
    @(negedge clk);
    n_checks++;
    if ({data_req, data_wr, data_wstrb, data_wdata, data_addr, MEM_memReq_o} !==
        {1'b1, 1'b1, 4'b0100, 32'h4444_4444, 32'h1002, 1'b0}) begin
      n_fail++;
      $display("FAIL sb_bus: got req=%b wr=%b strb=%b wdata=%h addr=%h mreq=%b, wanted 1 1 0100 44444444 00001002 0",
               data_req, data_wr, data_wstrb, data_wdata, data_addr, MEM_memReq_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending, wanted 0", sb.size()); end
  endtask

  task automatic test_adel_lh;
    WB_allowin_w_i = 1; data_addr_ok = 1;
    sb.push_back(mk(5'd0, 1'b1, EXC_ADEL, 32'h1003, 1'b0, LOAD_LH_BIT, 32'h1003, 32'hBFC0_0020));
    issue(MEM_OP_LH, 32'h1003, 32'hDEAD_BEEF, 5'd7, 32'hBFC0_0020);
    @(negedge clk);
    n_checks++;
    if ({data_req, MEM_valid_w_o, MEM_writeNum_w_o} !== {1'b0, 1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL adel_lh: got req=%b valid=%b fwd=%0d, wanted req=0 valid=1 fwd=0",
               data_req, MEM_valid_w_o, MEM_writeNum_w_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL adel_drain: got %0d pending, wanted 0", sb.size()); end
  endtask

  task automatic test_lw_stall;
    int acc = 0;
    int h0;
    WB_allowin_w_i = 0; data_addr_ok = 1;
    sb.push_back(mk(5'd9, 1'b0, 5'd0, 32'd0, 1'b1, LOAD_LW_BIT, 32'h2000, 32'hBFC0_0030));
    issue(MEM_OP_LW, 32'h2000, 32'h0, 5'd9, 32'hBFC0_0030);
    h0 = handovers;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({data_req, MEM_valid_w_o, MEM_writeNum_w_o} !== {1'b0, 1'b0, 5'd9}) begin
        n_fail++;
        $display("FAIL lw_stall_%0d: got req=%b valid=%b fwd=%0d, wanted 0 0 9",
                 i, data_req, MEM_valid_w_o, MEM_writeNum_w_o);
      end
      @(posedge clk); #1;
    end
    WB_allowin_w_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (data_req && data_addr_ok) acc++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (acc != 1 || handovers - h0 != 1) begin
      n_fail++;
      $display("FAIL lw_accept: got %0d acceptances %0d handovers, wanted 1 1", acc, handovers - h0);
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL lw_drain: got %0d pending, wanted 0", sb.size()); end
  endtask

  task automatic test_unaligned_lwl;
    WB_allowin_w_i = 1; data_addr_ok = 1;
`ifdef MEM_UNALIGNED_LS_EN
    sb.push_back(mk(5'd4, 1'b0, 5'd0, 32'd0, 1'b1, LOAD_L1_BIT, 32'h2001, 32'hBFC0_0040));
`else
    sb.push_back(mk(5'd0, 1'b1, EXC_ADEL, 32'h2001, 1'b0, LOAD_LW_BIT, 32'h2001, 32'hBFC0_0040));
`endif
    issue(MEM_OP_LWL, 32'h2001, 32'h0, 5'd4, 32'hBFC0_0040);
    @(negedge clk);
    n_checks++;
`ifdef MEM_UNALIGNED_LS_EN
    if (data_req !== 1'b1) begin n_fail++; $display("FAIL lwl_req: got %b, wanted 1", data_req); end
`else
    if (data_req !== 1'b0) begin n_fail++; $display("FAIL lwl_req: got %b, wanted 0", data_req); end
`endif
    @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL lwl_drain: got %0d pending, wanted 0", sb.size()); end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic        exc;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } st_vec_t;

  task automatic test_store_table;
    st_vec_t v[7];
    v[0] = '{MEM_OP_SH, 32'h3002, 1'b0, 4'b1100, 32'h3344_3344};
    v[1] = '{MEM_OP_SH, 32'h3001, 1'b1, 4'b0000, 32'h0};
    v[2] = '{MEM_OP_SW, 32'h3004, 1'b0, 4'b1111, 32'h1122_3344};
    v[3] = '{MEM_OP_SB, 32'h3003, 1'b0, 4'b1000, 32'h4444_4444};
`ifdef MEM_UNALIGNED_LS_EN
    v[4] = '{MEM_OP_SWL, 32'h3001, 1'b0, 4'b0011, 32'h0000_1122};
    v[5] = '{MEM_OP_SWR, 32'h3001, 1'b0, 4'b1110, 32'h2233_4400};
    v[6] = '{MEM_OP_SWL, 32'h3000, 1'b0, 4'b0001, 32'h0000_0011};
`else
    v[4] = '{MEM_OP_SWL, 32'h3001, 1'b1, 4'b0000, 32'h0};
    v[5] = '{MEM_OP_SWR, 32'h3001, 1'b1, 4'b0000, 32'h0};
    v[6] = '{MEM_OP_SWL, 32'h3000, 1'b0, 4'b1111, 32'h1122_3344};
`endif
    WB_allowin_w_i = 1; data_addr_ok = 1;
    for (int i = 0; i < 7; i++) begin
      sb.push_back(mk(5'd0, v[i].exc, v[i].exc ? EXC_ADES : 5'd0, v[i].exc ? v[i].addr : 32'd0,
                      1'b0, -1, v[i].addr, 32'hBFC0_0100 + i * 4));
      issue(v[i].op, v[i].addr, 32'h1122_3344, 5'd0, 32'hBFC0_0100 + i * 4);
      @(negedge clk);
      n_checks++;
      if (v[i].exc ? (data_req !== 1'b0)
                   : ({data_req, data_wr, data_wstrb, data_wdata} !== {2'b11, v[i].strb, v[i].wdata})) begin
        n_fail++;
        $display("FAIL store_%0d: got req=%b wr=%b strb=%b wdata=%h, wanted req=%b strb=%b wdata=%h",
                 i, data_req, data_wr, data_wstrb, data_wdata, !v[i].exc, v[i].strb, v[i].wdata);
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL store_drain: got %0d pending, wanted 0", sb.size()); end
  endtask

  task automatic test_load_table;
    WB_allowin_w_i = 1; data_addr_ok = 1;
    sb.push_back(mk(5'd5, 1'b0, 5'd0, 32'd0, 1'b1, LOAD_LB_BIT, 32'h4003, 32'hBFC0_0200));
    issue(MEM_OP_LB, 32'h4003, 32'h0, 5'd5, 32'hBFC0_0200);
    sb.push_back(mk(5'd5, 1'b0, 5'd0, 32'd0, 1'b1, LOAD_LHU_BIT, 32'h4002, 32'hBFC0_0204));
    issue(MEM_OP_LHU, 32'h4002, 32'h0, 5'd5, 32'hBFC0_0204);
`ifdef MEM_UNALIGNED_LS_EN
    sb.push_back(mk(5'd5, 1'b0, 5'd0, 32'd0, 1'b1, LOAD_R2_BIT, 32'h4002, 32'hBFC0_0208));
`else
    sb.push_back(mk(5'd0, 1'b1, EXC_ADEL, 32'h4002, 1'b0, LOAD_LW_BIT, 32'h4002, 32'hBFC0_0208));
`endif
    issue(MEM_OP_LWR, 32'h4002, 32'h0, 5'd5, 32'hBFC0_0208);
    sb.push_back(mk(5'd5, 1'b0, 5'd0, 32'd0, 1'b1, LOAD_LW_BIT, 32'h4000, 32'hBFC0_020C));
    issue(MEM_OP_LWR, 32'h4000, 32'h0, 5'd5, 32'hBFC0_020C);
    @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL load_drain: got %0d pending, wanted 0", sb.size()); end
  endtask

  task automatic test_flush;
    WB_allowin_w_i = 0; data_addr_ok = 0;
    issue(MEM_OP_LW, 32'h5000, 32'h0, 5'd6, 32'hBFC0_0300);
    flush_w_i = 1; WB_allowin_w_i = 1; data_addr_ok = 1;
    #1;
    n_checks++;
    if ({data_req, MEM_valid_w_o, MEM_writeNum_w_o} !== {1'b0, 1'b0, 5'd6}) begin
      n_fail++;
      $display("FAIL flush_req: got req=%b valid=%b fwd=%0d, wanted 0 0 6",
               data_req, MEM_valid_w_o, MEM_writeNum_w_o);
    end
    @(posedge clk); #1;
    flush_w_i = 0;
    n_checks++;
    if ({MEM_allowin_w_o, MEM_valid_w_o, MEM_writeNum_w_o, MEM_finalRes_o} !== {2'b10, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL flush_empty: got allowin=%b valid=%b fwd=%0d res=%h, wanted 1 0 0 0",
               MEM_allowin_w_o, MEM_valid_w_o, MEM_writeNum_w_o, MEM_finalRes_o);
    end
    EXE_memOp_i = MEM_OP_LW; EXE_finalRes_i = 32'h5100; EXE_writeNum_i = 5'd3;
    EXE_valid_w_i = 1; flush_w_i = 1;
    @(posedge clk); #1;
    EXE_valid_w_i = 0; flush_w_i = 0; EXE_memOp_i = 0;
    n_checks++;
    if ({MEM_allowin_w_o, MEM_writeNum_w_o, MEM_finalRes_o} !== {1'b1, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL flush_vs_load: got allowin=%b fwd=%0d res=%h, wanted 1 0 0",
               MEM_allowin_w_o, MEM_writeNum_w_o, MEM_finalRes_o);
    end
  endtask

  task automatic test_async_reset;
    WB_allowin_w_i = 0; data_addr_ok = 0;
    issue(MEM_OP_LW, 32'h6000, 32'h55AA_55AA, 5'd8, 32'hBFC0_0400);
    #1; WB_allowin_w_i = 1;
    #1;
    n_checks++;
    if (data_req !== 1'b1) begin n_fail++; $display("FAIL async_pre: got req=%b, wanted 1", data_req); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (all_out !== '0) begin n_fail++; $display("FAIL async_reset: got %h, wanted 0", all_out); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, wanted completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_sb();
    test_adel_lh();
    test_lw_stall();
    test_unaligned_lwl();
    test_store_table();
    test_load_table();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage, between EXE and WriteBack.
- Latches the EXE result and issues the data-bus request for loads and stores.
- Builds store byte-strobes and write data, and encodes the one-hot load selector plus alignment used by WriteBack for load data extraction.
- Detects address-error exceptions and runs the valid/allowin interlock with its neighbours.

Parameters:
- ADDR_W, 32, virtual/bus address width.
- DATA_W, 32, data word width (only 32 supported).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- EXE_valid_w_i  in  1  EXE has an instruction to hand over
- WB_allowin_w_i  in  1  WriteBack can accept this cycle
- flush_w_i  in  1  exception/eret flush; kills the MEM entry
- EXE_writeNum_i  in  5  destination GPR, 0 means no write
- EXE_finalRes_i  in  32  ALU/mul/cp0 result; holds the address for mem ops
- EXE_rtData_i  in  32  rt operand (store data, lwl/lwr merge)
- EXE_memOp_i  in  4  MEM_OP_* code
- EXE_pc_i  in  32  instruction PC
- EXE_isDangerous_i  in  1  danger flag, passed through
- MEM_allowin_w_o  out  1  MEM can accept from EXE
- MEM_valid_w_o  out  1  entry ready to move to WB
- MEM_writeNum_w_o  out  5  forwarding number for ID
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_wstrb  out  4  byte strobes
- data_addr  out  32  bus address
- data_wdata  out  32  store data
- data_addr_ok  in  1  request accepted; read data is valid on data_rdata the next cycle
- MEM_writeNum_o  out  5  to WB
- MEM_exceptionRisk_o  out  1  AdEL/AdES detected
- MEM_excCode_o  out  5  0x04 AdEL, 0x05 AdES, else 0
- MEM_badVAddr_o  out  32  faulting address
- MEM_memReq_o  out  1  accepted load in flight
- MEM_VAddr_o  out  32  PC for debug trace
- MEM_isDangerous_o  out  1  pass-through
- MEM_finalRes_o  out  32  registered EXE result
- MEM_rtData_o  out  32  registered rt
- MEM_alignCheck_o  out  2  address[1:0]
- MEM_loadSel_o  out  11  one-hot load selector

Behaviour:
- Reset: asynchronous, active-low on rst. All registers, FSM = EMPTY and every output clear to 0; data_req = 0.
- Entry register:
  - Loads when MEM_allowin_w_o && EXE_valid_w_i.
  - Clears when MEM_allowin_w_o && !EXE_valid_w_i, or on flush_w_i; flush has priority over load.
- FSM:
  - EMPTY -> WAIT_BUS when a load/store without address error is loaded.
  - EMPTY -> READY when a non-memory op, or a memory op with an exception, is loaded.
  - WAIT_BUS -> READY-and-leave on data_req && data_addr_ok. READY leaves when WB_allowin_w_i.
  - Every state returns to EMPTY on flush, or to the newly loaded class.
- data_req = (state == WAIT_BUS) && WB_allowin_w_i && !flush_w_i.
  - The request may drop before acceptance; the bus does not commit until data_addr_ok.
  - Acceptance and the move to WB always occur in the same cycle, so WB samples data_rdata exactly one cycle after addr_ok.
- MEM_valid_w_o = (state == READY) || (state == WAIT_BUS && data_req && data_addr_ok).
- MEM_allowin_w_o = (state == EMPTY) || (MEM_valid_w_o && WB_allowin_w_i).
- Address alignment: a = finalRes[1:0]. data_addr = finalRes.
- Address errors:
  - AdEL: LH/LHU with a[0] set; LW with a != 0.
  - AdES: SH with a[0] set; SW with a != 0.
  - On error: no request, MEM_exceptionRisk_o = 1, MEM_badVAddr_o = address, writeNum forced to 0.
- Store strobes and write data:
  - SB: strb = 0001 << a; wdata = rt[7:0] replicated 4 times.
  - SH: strb = 0011 or 1100; wdata = rt[15:0] replicated 2 times.
  - SW: strb = 1111; wdata = rt.
  - SWL: strb a0 0001, a1 0011, a2 0111, a3 1111; wdata = rt >> (24 - 8a).
  - SWR: strb a0 1111, a1 1110, a2 1100, a3 1000; wdata = rt << 8a.
- loadSel one-hot bits, decided by memOp and a:
  - LB, LBU, LH, LHU, LW as named.
  - LWL: a0 -> L0, a1 -> L1, a2 -> L2, a3 -> LW.
  - LWR: a3 -> R3, a2 -> R2, a1 -> R1, a0 -> LW.
- MEM_memReq_o: set only for an accepted load. It is 0 for stores, non-mem ops and exceptions.
- MEM_writeNum_w_o = writeNum of the current entry, or 0 when EMPTY.
- Simultaneous events:
  - flush with addr_ok in the same cycle: data_req is already 0, so no acceptance.
  - flush with EXE load in the same cycle: flush wins.

Optional Feature:
- MEM_UNALIGNED_LS_EN defined: LWL/LWR/SWL/SWR decode exactly as above.
- Not defined:
  - MEM_OP_LWL/LWR behave as LW, including AdEL.
  - MEM_OP_SWL/SWR behave as SW, including AdES.
  - L0..L2 and R1..R3 are never asserted.

Decomposition:
- Shared package/defines:
  - MEM_OP_* codes: NONE 0, LB 1, LBU 2, LH 3, LHU 4, LW 5, LWL 6, LWR 7, SB 8, SH 9, SW 10, SWL 11, SWR 12.
  - LOAD_SEL width 11 and LOAD_*_BIT indices.
  - EXC_ADEL and EXC_ADES codes.
  - FSM state encodings.
- One natural combinational sub-module: mem_lsu_encode (memOp, address, rt -> strobes, wdata, loadSel, AdE flags).

Test Plan:
- SB, rt = 0x11223344, addr 0x1002, WB allows, addr_ok = 1 -> data_req = 1, wstrb = 0100, wdata = 0x44444444, memReq = 0.
- LH at 0x1003 -> no data_req; excCode = 0x04; badVAddr = 0x1003; writeNum = 0; valid the next cycle.
- LW at 0x2000, WB_allowin low for 3 cycles, then addr_ok -> data_req only while allowin is high; single acceptance; memReq = 1; loadSel = LW.
- LWL at 0x2001, macro on -> loadSel = L1, alignCheck = 01. Macro off -> AdEL.
- Flush while in WAIT_BUS with addr_ok high -> data_req = 0, next state EMPTY, MEM_valid = 0.
- rst low during WAIT_BUS -> all outputs 0 immediately, without waiting for a clock edge.
